seq_multiplier: RTL

- Iterative multi-cycle signed/unsigned integer multiplier producing the full 2N-bit product.
- Successor to the single-cycle combinational multiplier. Trades latency for area by retiring K multiplier bits per cycle.
- Operand and result sides each use a valid/ready handshake.
- Sits beside the ALU. The datapath issues one multiply and stalls or overlaps until the result returns.

---
 rtl/seq_multiplier_pkg.sv | 20 ++
 rtl/seq_multiplier_if.sv | 29 ++
 rtl/mul_digit_step.sv | 22 ++
 rtl/seq_multiplier.sv | 121 ++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// the elaboration-time legality check on the digit width K.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

package seq_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic bit k_is_legal(input int unsigned n, input int unsigned k);
        return ((k == 1) || (k == 2) || (k == 4)) && (n >= k) && ((n % k) == 0);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle of the iterative multiplier.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

interface seq_multiplier_if #(
    parameter int N = `DEFAULT_WIDTH
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           sign;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] prod;
    logic           busy;

    modport master (
        output in_valid, a, b, sign, flush, out_ready,
        input  in_ready, out_valid, prod, busy
    );

    modport slave (
        input  in_valid, a, b, sign, flush, out_ready,
        output in_ready, out_valid, prod, busy
    );
endinterface

// File: rtl/mul_digit_step.sv
// One iteration of the shift-and-add multiplier: adds the partial product of
// the multiplicand magnitude and one K-bit digit, shifted into place.
module mul_digit_step #(
    parameter int N  = 8,
    parameter int K  = 1,
    parameter int SW = 4
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   av,
    input  logic [K-1:0]   d,
    input  logic [SW-1:0]  shift,
    output logic [2*N-1:0] acc_next
);
    localparam int W = 2 * N;

    logic [W-1:0] term;

    always_comb begin
        term     = (W'(av) * W'(d)) << shift;
        acc_next = acc + term;
    end
endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier retiring K multiplier bits per cycle;
// magnitudes are multiplied and the sign is applied in a single FIX cycle.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int N = `DEFAULT_WIDTH,
    parameter int K = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_multiplier_if.slave  bus
);
    localparam int unsigned ITERS = N / K;
    localparam int          CW    = $clog2(ITERS + 1);
    localparam int          SW    = $clog2(2 * N);

    if (!k_is_legal(N, K)) begin : g_illegal_k
        $fatal(1, "seq_multiplier: K must be 1, 2 or 4 and divide N");
    end

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   av;
    logic [N-1:0]   bq;
    logic           s;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] acc_next;
    logic [2*N-1:0] prod_q;
    logic [CW-1:0]  cnt;
    logic [SW-1:0]  pos;
    logic           as_in;
    logic           bs_in;
    logic [N-1:0]   av_in;
    logic [N-1:0]   bv_in;
    logic           accept;

    // flush outranks a same-cycle in_valid while idle
    assign accept = (state == IDLE) && bus.in_valid && !bus.flush;
    assign as_in  = bus.sign & bus.a[N-1];
    assign bs_in  = bus.sign & bus.b[N-1];
    assign av_in  = as_in ? -bus.a : bus.a;
    assign bv_in  = bs_in ? -bus.b : bus.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
                if (bus.flush)             state_next = IDLE;
                else if (cnt == CW'(1))    state_next = FIX;
            end
            FIX:     state_next = bus.flush ? IDLE : DONE;
            DONE:    if (bus.flush || bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // bq shifts down so the current digit is always its low K bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            av     <= '0;
            bq     <= '0;
            s      <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            pos    <= '0;
            prod_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        av  <= av_in;
                        bq  <= bv_in;
                        s   <= as_in ^ bs_in;
                        acc <= '0;
                        cnt <= CW'(ITERS);
                        pos <= '0;
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        acc <= acc_next;
                        bq  <= bq >> K;
                        cnt <= cnt - CW'(1);
                        pos <= pos + SW'(K);
                    end
                end
                FIX: begin
                    if (!bus.flush) prod_q <= s ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

    mul_digit_step #(
        .N  (N),
        .K  (K),
        .SW (SW)
    ) u_step (
        .acc      (acc),
        .av       (av),
        .d        (bq[K-1:0]),
        .shift    (pos),
        .acc_next (acc_next)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.prod      = prod_q;
endmodule
